ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one 2-cycle-read-latency dual-port RAM (immediate write, read data 2 clocks after address) among NUM_PORTS requesters on a single clock domain.
- Round-robin arbitration issues at most one access (read or write) per cycle to the RAM.
- Read data is routed back to the issuing requester via a latency-matched tag pipeline.
- Sits between processing cores / DMA engines and a shared memory; both RAM clocks tie to clk.

Parameters:
NUM_PORTS, 4, number of requesters (2..16)
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 12, RAM address width
READ_LATENCY, 2, RAM read latency in clocks; tag pipeline depth

Ports:
clk  input  1  single clock; RAM read_clock and write_clock both driven from clk
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_PORTS  per-port access request, held until granted
we  input  NUM_PORTS  per-port write (1) / read (0) select, valid with req
addr  input  NUM_PORTS*ADDR_WIDTH  per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  input  NUM_PORTS*DATA_WIDTH  per-port write data, same packing
gnt  output  NUM_PORTS  one-hot grant, combinational, same cycle as accepted req
rvalid  output  NUM_PORTS  one-hot read-data-valid, registered
rdata  output  DATA_WIDTH  read data, broadcast; qualify with rvalid
ram_read_addr  output  ADDR_WIDTH  to RAM read_addr
ram_write_addr  output  ADDR_WIDTH  to RAM write_addr
ram_data_in  output  DATA_WIDTH  to RAM data_in
ram_we  output  1  to RAM we
ram_data_out  input  DATA_WIDTH  from RAM data_out

Behaviour:
- Reset (reset_n low, async): rr pointer = NUM_PORTS-1 so port 0 has highest priority first; tag pipeline valid bits = 0; rvalid = 0. While reset_n low, gnt = 0 and ram_we = 0 (gated combinationally).
- Arbitration each cycle: search ports starting at pointer+1 mod NUM_PORTS and wrap; the first with req=1 gets gnt. No req means gnt=0 and the pointer is held.
- On a grant to port k, the pointer becomes k at the next clk edge. A port can be granted on consecutive cycles only if no other port requests.
- Handshake: a transfer occurs in the cycle req[k]&gnt[k]=1. The requester may change addr/wdata/we or drop req on the following cycle. Dropping req before grant is legal and nothing is issued.
- Granted write: ram_we=1, ram_write_addr=addr[k], ram_data_in=wdata[k] in the same cycle. The RAM commits at that clk edge, so write latency is 0.
- Granted read: ram_read_addr=addr[k] in the grant cycle T; ram_we=0. Tag stage0 captures {valid=1, id=k} at edge T. Each tag stage shifts once per clock for READ_LATENCY stages.
- Read return: rvalid[k]=1 in cycle T+READ_LATENCY (registered from last tag stage), and rdata=ram_data_out in that cycle. Reads are back-to-back capable: one result per cycle, in issue order.
- Read-after-write: a write granted in cycle T is visible to a read granted in T+1 or later. No same-cycle read+write (single grant).
- Non-granted cycles: ram_we=0. ram_read_addr/ram_write_addr/ram_data_in are don't-care but must be driven from port 0 values (no X), to ease waveforms.
- rvalid is at most one-hot. The tag id width is clog2(NUM_PORTS), minimum 1.
- Reset mid-operation: all in-flight reads are discarded (no rvalid after reset release for reads issued before). RAM contents are untouched. Arbitration restarts from port 0.
- No starvation: any held req is granted within NUM_PORTS cycles.

Test Plan:
- Reset release, port 0 writes 0xDEADBEEF @0x010, then reads 0x010 next cycle -> gnt[0] both cycles, rvalid[0]=1 exactly 2 cycles after read grant with rdata=0xDEADBEEF.
- All 4 ports assert req (reads to addrs 1..4, preloaded data 0x11..0x44) held continuously -> grants 0,1,2,3,0,... one per cycle; rvalid one-hot sequence 0,1,2,3 with rdata 0x11,0x22,0x33,0x44 starting 2 cycles after first grant.
- Ports 1 and 3 requesting, pointer at 1 -> gnt[3] first, then gnt[1]; port 3 re-request is not granted before port 1.
- Ports 2 (write 0x5A5A5A5A @0x020) and 0 (read 0x020) simultaneous, pointer=1 -> port 2 granted first, read returns 0x5A5A5A5A.
- Read granted, reset_n pulsed low for one cycle before return -> rvalid stays 0 throughout; next req on port 0 is granted first.
- Idle (req=0) for 10 cycles -> gnt=0, ram_we=0, rvalid=0, pointer unchanged.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM among NUM_PORTS requesters.
// Read data is steered back to its requester through a tag pipeline matched to the RAM latency.
module ram_port_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [ADDR_WIDTH-1:0]           ram_read_addr,
  output logic [ADDR_WIDTH-1:0]           ram_write_addr,
  output logic [DATA_WIDTH-1:0]           ram_data_in,
  output logic                            ram_we,
  input  logic [DATA_WIDTH-1:0]           ram_data_out
);

  localparam int IdW  = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int Last = READ_LATENCY - 1;

  logic [IdW-1:0]          ptr_q, ptr_d;
  logic                    grantValid;
  logic [IdW-1:0]          grantId;
  logic [IdW-1:0]          selId;
  logic [READ_LATENCY-1:0] tagValid_q, tagValid_d;
  logic [IdW-1:0]          tagId_q [READ_LATENCY];
  logic [IdW-1:0]          tagId_d [READ_LATENCY];

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    int cand;
    logic [IdW-1:0] candId;
    cand       = 0;
    candId     = '0;
    grantValid = 1'b0;
    grantId    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand   = (int'(ptr_q) + i) % NUM_PORTS;
      candId = IdW'(cand);
      if (!grantValid && req[candId]) begin
        grantValid = 1'b1;
        grantId    = candId;
      end
    end
    if (!reset_n) begin
      grantValid = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (grantValid) begin
      gnt[grantId] = 1'b1;
    end
    ptr_d = grantValid ? grantId : ptr_q;
  end

  // Idle cycles still present port 0's values to the RAM so its inputs never float.
  always_comb begin
    selId          = grantValid ? grantId : '0;
    ram_read_addr  = addr[selId*ADDR_WIDTH +: ADDR_WIDTH];
    ram_write_addr = addr[selId*ADDR_WIDTH +: ADDR_WIDTH];
    ram_data_in    = wdata[selId*DATA_WIDTH +: DATA_WIDTH];
    ram_we         = grantValid & we[grantId];
  end

  always_comb begin
    tagValid_d[0] = grantValid & ~we[grantId];
    tagId_d[0]    = grantId;
    for (int s = 1; s < READ_LATENCY; s++) begin
      tagValid_d[s] = tagValid_q[s-1];
      tagId_d[s]    = tagId_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= IdW'(NUM_PORTS - 1);
      tagValid_q <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        tagId_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      tagValid_q <= tagValid_d;
      for (int s = 0; s < READ_LATENCY; s++) begin
        tagId_q[s] <= tagId_d[s];
      end
    end
  end

  // The last tag stage lines up with the RAM's data_out, so rvalid decodes straight from its flops.
  always_comb begin
    rvalid = '0;
    if (tagValid_q[Last]) begin
      rvalid[tagId_q[Last]] = 1'b1;
    end
    rdata = ram_data_out;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic against a
// behavioural reference (round-robin rule, shadow memory, queue of outstanding reads).
module tb_ram_port_arbiter;

  localparam int NumPorts = 4;
  localparam int DataW    = 32;
  localparam int AddrW    = 12;
  localparam int ReadLat  = 2;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NumPorts-1:0]       req, we, gnt, rvalid;
  logic [NumPorts*AddrW-1:0] addr;
  logic [NumPorts*DataW-1:0] wdata;
  logic [DataW-1:0]          rdata, ram_data_in, ram_data_out;
  logic [AddrW-1:0]          ram_read_addr, ram_write_addr;
  logic                      ram_we;

  ram_port_arbiter #(
    .NUM_PORTS(NumPorts), .DATA_WIDTH(DataW), .ADDR_WIDTH(AddrW), .READ_LATENCY(ReadLat)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Shared RAM: write commits at the edge, read data appears two edges after the address.
  logic [DataW-1:0] ramMem [0:4095];
  logic [AddrW-1:0] ramRa1;
  always @(posedge clk) begin
    ramRa1       <= ram_read_addr;
    ram_data_out <= ramMem[ramRa1];
    if (ram_we) ramMem[ram_write_addr] <= ram_data_in;
  end

  // Stimulus state, one entry per requester.
  logic                rstV;
  logic [NumPorts-1:0] reqV, weV;
  logic [AddrW-1:0]    addrV  [NumPorts];
  logic [DataW-1:0]    wdataV [NumPorts];

  // Reference model.
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rdEntry_t;
  rdEntry_t    pending[$];
  logic [31:0] shadow [0:4095];
  int          mPtr;
  int          cyc;
  int          curGrant;
  int          nChecks = 0;
  int          nFails  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus();
    reset_n = rstV;
    req     = reqV;
    we      = weV;
    for (int p = 0; p < NumPorts; p++) begin
      addr[p*AddrW +: AddrW]  = addrV[p];
      wdata[p*DataW +: DataW] = wdataV[p];
    end
  endtask

  // Compares every DUT output against the model for the current cycle.
  task automatic checkOutput();
    logic [31:0] expRv, expData;
    bit          hit;
    int          p;
    curGrant = -1;
    if (rstV) begin
      for (int i = 1; i <= NumPorts; i++) begin
        p = (mPtr + i) % NumPorts;
        if (curGrant < 0 && reqV[p]) curGrant = p;
      end
    end
    cmp("gnt", gnt, (curGrant >= 0) ? (32'd1 << curGrant) : 32'd0);
    cmp("ram_we", ram_we, (curGrant >= 0) ? weV[curGrant] : 1'b0);
    if (curGrant >= 0) begin
      if (weV[curGrant]) begin
        cmp("ram_write_addr", ram_write_addr, addrV[curGrant]);
        cmp("ram_data_in", ram_data_in, wdataV[curGrant]);
      end else begin
        cmp("ram_read_addr", ram_read_addr, addrV[curGrant]);
      end
    end else begin
      cmp("idle_read_addr", ram_read_addr, addrV[0]);
      cmp("idle_write_addr", ram_write_addr, addrV[0]);
      cmp("idle_data_in", ram_data_in, wdataV[0]);
    end
    if (!rstV) pending.delete();
    expRv   = 0;
    expData = 0;
    hit     = 0;
    foreach (pending[i]) begin
      if (pending[i].due == cyc) begin
        expRv   = 32'd1 << pending[i].port;
        expData = pending[i].data;
        hit     = 1;
      end
    end
    cmp("rvalid", rvalid, expRv);
    if (hit) cmp("rdata", rdata, expData);
    while (pending.size() > 0 && pending[0].due <= cyc) void'(pending.pop_front());
  endtask

  task automatic advanceModel();
    if (!rstV) begin
      mPtr = NumPorts - 1;
    end else if (curGrant >= 0) begin
      mPtr = curGrant;
      if (weV[curGrant]) shadow[addrV[curGrant]] = wdataV[curGrant];
      else pending.push_back('{due: cyc + ReadLat, port: curGrant, data: shadow[addrV[curGrant]]});
    end
    cyc++;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    advanceModel();
  endtask

  task automatic idleInputs();
    reqV = '0;
    weV  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      addrV[p]  = '0;
      wdataV[p] = '0;
    end
  endtask

  task automatic resetPulse();
    rstV = 1'b0;
    stepCycle();
    cmp("reset_gnt", gnt, 0);
    cmp("reset_rvalid", rvalid, 0);
    cmp("reset_ram_we", ram_we, 0);
    rstV = 1'b1;
  endtask

  task automatic randomizeRequests();
    for (int p = 0; p < NumPorts; p++) begin
      if (curGrant == p || !reqV[p]) begin
        reqV[p]   = ($urandom_range(0, 9) < 6);
        weV[p]    = ($urandom_range(0, 2) == 0);
        addrV[p]  = AddrW'($urandom_range(0, 31));
        wdataV[p] = $urandom();
      end else if ($urandom_range(0, 19) == 0) begin
        reqV[p] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      ramMem[a] = a * 32'h11;
      shadow[a] = a * 32'h11;
    end
    mPtr = NumPorts - 1;
    cyc  = 0;
    idleInputs();
    rstV = 1'b0;
    applyStimulus();

    // Write then read-back from port 0; a request held during reset must not be granted.
    reqV[0] = 1'b1;
    resetPulse();
    weV[0] = 1'b1; addrV[0] = 12'h010; wdataV[0] = 32'hDEADBEEF;
    stepCycle();
    cmp("t1_write_gnt", gnt, 4'b0001);
    cmp("t1_write_we", ram_we, 1'b1);
    weV[0] = 1'b0;
    stepCycle();
    cmp("t1_read_gnt", gnt, 4'b0001);
    idleInputs();
    stepCycle();
    cmp("t1_rvalid_early", rvalid, 4'b0000);
    stepCycle();
    cmp("t1_rvalid", rvalid, 4'b0001);
    cmp("t1_rdata", rdata, 32'hDEADBEEF);

    // All ports read addresses 1..4 continuously.
    resetPulse();
    for (int p = 0; p < NumPorts; p++) begin
      reqV[p] = 1'b1; addrV[p] = AddrW'(p + 1);
    end
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      cmp("t2_gnt", gnt, 32'd1 << (k % 4));
      if (k >= 2) begin
        cmp("t2_rvalid", rvalid, 32'd1 << ((k - 2) % 4));
        cmp("t2_rdata", rdata, (((k - 2) % 4) + 1) * 32'h11);
      end
    end
    idleInputs();
    repeat (3) stepCycle();

    // Ports 1 and 3 with pointer at 1.
    reqV[1] = 1'b1; addrV[1] = 12'h005;
    stepCycle();
    cmp("t3_setup_gnt", gnt, 4'b0010);
    reqV[3] = 1'b1; addrV[3] = 12'h006;
    stepCycle();
    cmp("t3_first_gnt", gnt, 4'b1000);
    stepCycle();
    cmp("t3_second_gnt", gnt, 4'b0010);
    reqV[1] = 1'b0;
    stepCycle();
    cmp("t3_third_gnt", gnt, 4'b1000);
    idleInputs();
    repeat (3) stepCycle();

    // Write from port 2 and read of the same address from port 0, pointer at 1.
    reqV[1] = 1'b1;
    stepCycle();
    idleInputs();
    reqV[2] = 1'b1; weV[2] = 1'b1; addrV[2] = 12'h020; wdataV[2] = 32'h5A5A5A5A;
    reqV[0] = 1'b1; addrV[0] = 12'h020;
    stepCycle();
    cmp("t4_write_gnt", gnt, 4'b0100);
    reqV[2] = 1'b0;
    stepCycle();
    cmp("t4_read_gnt", gnt, 4'b0001);
    reqV[0] = 1'b0;
    stepCycle();
    stepCycle();
    cmp("t4_rvalid", rvalid, 4'b0001);
    cmp("t4_rdata", rdata, 32'h5A5A5A5A);

    // Reset while a read is in flight.
    idleInputs();
    reqV[2] = 1'b1;
    stepCycle();
    reqV[2] = 1'b0;
    reqV[0] = 1'b1; addrV[0] = 12'h003;
    stepCycle();
    cmp("t5_read_gnt", gnt, 4'b0001);
    reqV[0] = 1'b0;
    resetPulse();
    stepCycle();
    cmp("t5_rvalid_after", rvalid, 4'b0000);
    reqV[0] = 1'b1; reqV[2] = 1'b1;
    stepCycle();
    cmp("t5_restart_gnt", gnt, 4'b0001);
    idleInputs();
    repeat (3) stepCycle();

    // Idle period; pointer (at 0) must be preserved.
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      cmp("t6_idle_gnt", gnt, 4'b0000);
      cmp("t6_idle_we", ram_we, 1'b0);
      cmp("t6_idle_rvalid", rvalid, 4'b0000);
    end
    reqV = '1;
    stepCycle();
    cmp("t6_ptr_kept_gnt", gnt, 4'b0010);
    idleInputs();
    repeat (3) stepCycle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      randomizeRequests();
      if (!rstV) rstV = 1'b1;
      else if ($urandom_range(0, 149) == 0) rstV = 1'b0;
      stepCycle();
    end
    rstV = 1'b1;
    idleInputs();
    repeat (4) stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
